// File: rtl/w_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : w_schedule_ctrl
// Brief    : SHA-256 message-schedule sequencer; expands a 512-bit block in a
//            16-word sliding window and streams W[0..W_LENGTH-1] with
//            valid/ready backpressure. Optional w_vector output: W_VECTOR_OUT_EN.
// Revision : 1.0
// ============================================================================
module w_schedule_ctrl #(
    parameter int W_LENGTH = 64,
    parameter int IDX_W    = $clog2(W_LENGTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  abort,
    input  logic                  msg_valid,
    output logic                  msg_ready,
    input  logic [511:0]          msg_block,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [31:0]           w_word,
    output logic [IDX_W-1:0]      w_index,
    output logic                  w_last,
    output logic                  block_done
`ifdef W_VECTOR_OUT_EN
    ,
    output logic [32*W_LENGTH-1:0] w_vector
`endif
);

    localparam logic [1:0]       S_IDLE   = 2'd0;
    localparam logic [1:0]       S_STREAM = 2'd1;
    localparam logic [1:0]       S_DONE   = 2'd2;
    localparam logic [IDX_W-1:0] C_LAST_T = IDX_W'(W_LENGTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [31:0]      r_win [16];
    logic [IDX_W-1:0] r_t;
    logic             w_accept;
    logic             w_hs;
    logic [31:0]      w_sigma0;
    logic [31:0]      w_sigma1;
    logic [31:0]      w_new_word;

    assign w_accept = msg_valid && msg_ready;
    assign w_hs     = w_valid && w_ready;

    assign w_sigma0 = {r_win[1][6:0],   r_win[1][31:7]}
                    ^ {r_win[1][17:0],  r_win[1][31:18]}
                    ^ (r_win[1] >> 3);
    assign w_sigma1 = {r_win[14][16:0], r_win[14][31:17]}
                    ^ {r_win[14][18:0], r_win[14][31:19]}
                    ^ (r_win[14] >> 10);
    assign w_new_word = w_sigma1 + r_win[9] + w_sigma0 + r_win[0];

    // State register: reset beats abort, abort beats any handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (abort) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next_state = S_STREAM;
            S_STREAM: if (w_ready && (r_t == C_LAST_T)) w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Outputs are zero outside STREAM so a flushed or reset block leaves no residue
    always_comb begin
        msg_ready  = 1'b0;
        w_valid    = 1'b0;
        w_word     = 32'd0;
        w_index    = '0;
        w_last     = 1'b0;
        block_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                msg_ready = !abort && !reset;
            end
            S_STREAM: begin
                w_valid = 1'b1;
                w_word  = r_win[0];
                w_index = r_t;
                w_last  = (r_t == C_LAST_T);
            end
            S_DONE: begin
                block_done = 1'b1;
            end
            default: begin
                msg_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) r_win[i] <= 32'd0;
            r_t <= '0;
        end else if (abort) begin
            r_t <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < 16; i++) r_win[i] <= msg_block[32*i +: 32];
            r_t <= '0;
        end else if (w_hs) begin
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= w_new_word;
            r_t       <= r_t + 1'b1;
        end
    end

`ifdef W_VECTOR_OUT_EN
    logic [32*W_LENGTH-1:0] r_vector;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vector <= '0;
        end else if (abort) begin
            r_vector <= r_vector;
        end else if (w_accept) begin
            r_vector <= '0;
        end else if (w_hs) begin
            r_vector[32*r_t +: 32] <= r_win[0];
        end
    end

    assign w_vector = r_vector;
`endif

endmodule
`default_nettype wire

// File: tb/tb_w_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_w_schedule_ctrl
// Brief    : Self-checking bench for w_schedule_ctrl against a direct
//            SHA-256 schedule model.
// Revision : 1.0
// ============================================================================
module tb_w_schedule_ctrl;

    localparam int WL = 64;
    localparam int IW = 6;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           abort = 1'b0;
    logic           msg_valid = 1'b0;
    logic           msg_ready;
    logic [511:0]   msg_block = '0;
    logic           w_valid;
    logic           w_ready = 1'b0;
    logic [31:0]    w_word;
    logic [IW-1:0]  w_index;
    logic           w_last;
    logic           block_done;
`ifdef W_VECTOR_OUT_EN
    logic [32*WL-1:0] w_vector;
`endif

    w_schedule_ctrl #(.W_LENGTH(WL)) dut (
        .clock      (clock),
        .reset      (reset),
        .abort      (abort),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_block  (msg_block),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_word     (w_word),
        .w_index    (w_index),
        .w_last     (w_last),
        .block_done (block_done)
`ifdef W_VECTOR_OUT_EN
        ,
        .w_vector   (w_vector)
`endif
    );

    always #5 clock = ~clock;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ref_w [WL];
    bit          abc_run  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook schedule: W[t] computed directly from earlier W values
    task automatic make_ref(input logic [511:0] b);
        for (int t = 0; t < WL; t++) begin
            if (t < 16) ref_w[t] = b[32*t +: 32];
            else ref_w[t] = (rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                          + ref_w[t-7]
                          + (rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                          + ref_w[t-16];
        end
    endtask

    task automatic rand_block(output logic [511:0] b);
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    endtask

    // Presents a block and returns at the negedge after its acceptance edge
    task automatic send(input logic [511:0] b, input bit keep);
        int n;
        n = 0;
        @(negedge clock);
        msg_block = b;
        msg_valid = 1'b1;
        make_ref(b);
        #1;
        while (!msg_ready && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("accept_ready", {63'd0, msg_ready}, 64'd1);
        @(posedge clock);
        @(negedge clock);
        if (!keep) msg_valid = 1'b0;
    endtask

    // kind: 1 = abort at stop_at, 2 = reset at stop_at
    task automatic stream(input bit rnd, input int stop_at, input int kind);
        int t;
        int cyc;
        bit done;
        t = 0;
        cyc = 0;
        done = 0;
        while (!done && cyc < 1000) begin
            if (cyc > 0) @(negedge clock);
            w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (t == stop_at) begin
                if (kind == 1) abort = 1'b1;
                else reset = 1'b1;
            end
            #1;
            chk("w_valid", {63'd0, w_valid}, 64'd1);
            chk("w_index", {58'd0, w_index}, 64'(t));
            chk("w_word", {32'd0, w_word}, {32'd0, ref_w[t]});
            chk("w_last", {63'd0, w_last}, {63'd0, t == WL - 1});
            chk("no_done_mid", {63'd0, block_done}, 64'd0);
            if (abc_run) begin
                case (t)
                    16: chk("abc_w16", {32'd0, w_word}, 64'h61626380);
                    17: chk("abc_w17", {32'd0, w_word}, 64'h000F0000);
                    18: chk("abc_w18", {32'd0, w_word}, 64'h7DA86405);
                    19: chk("abc_w19", {32'd0, w_word}, 64'h600003C6);
                    default: ;
                endcase
            end
            if (t == stop_at) begin
                @(posedge clock);
                @(negedge clock);
                #1;
                if (kind == 1) begin
                    abort = 1'b0;
                    #1;
                    chk("abort_w_valid", {63'd0, w_valid}, 64'd0);
                    chk("abort_msg_ready", {63'd0, msg_ready}, 64'd1);
                    chk("abort_no_done", {63'd0, block_done}, 64'd0);
                end else begin
                    chk("rst_outputs", {msg_ready, w_valid, w_last, block_done, w_index, w_word},
                        64'd0);
                    reset = 1'b0;
                    #1;
                    chk("rst_release_ready", {63'd0, msg_ready}, 64'd1);
                    chk("rst_release_valid", {63'd0, w_valid}, 64'd0);
                end
                return;
            end
            @(posedge clock);
            if (w_ready) begin
                if (t == WL - 1) done = 1;
                t++;
            end
            cyc++;
        end
        if (!done) chk("stream_timeout", 64'd0, 64'd1);
        @(negedge clock);
        #1;
        chk("done_pulse", {63'd0, block_done}, 64'd1);
        chk("done_w_valid", {63'd0, w_valid}, 64'd0);
        chk("done_msg_ready", {63'd0, msg_ready}, 64'd0);
`ifdef W_VECTOR_OUT_EN
        for (int i = 0; i < WL; i++)
            chk("w_vector", {32'd0, w_vector[32*i +: 32]}, {32'd0, ref_w[i]});
        if (abc_run) begin
            chk("vec_abc_w0", {32'd0, w_vector[31:0]}, 64'h61626380);
            chk("vec_abc_w17", {32'd0, w_vector[575:544]}, 64'h000F0000);
        end
`endif
    endtask

    initial begin
        logic [511:0] abc;
        logic [511:0] b1;
        logic [511:0] b2;

        abc = '0;
        abc[31:0]    = 32'h61626380;
        abc[511:480] = 32'h00000018;

        repeat (3) @(negedge clock);
        #1;
        chk("reset_outputs", {msg_ready, w_valid, w_last, block_done, w_index, w_word}, 64'd0);
        reset = 1'b0;
        #1;
        chk("idle_msg_ready", {63'd0, msg_ready}, 64'd1);
        chk("idle_w_valid", {63'd0, w_valid}, 64'd0);

        // "abc" block, consumer always ready
        abc_run = 1;
        send(abc, 0);
        stream(0, -1, 0);
        @(negedge clock);
        #1;
        chk("abc_back_idle", {63'd0, msg_ready}, 64'd1);

        // Same block under random backpressure
        send(abc, 0);
        stream(1, -1, 0);
        abc_run = 0;

        // Back-to-back with msg_valid held high
        rand_block(b1);
        rand_block(b2);
        send(b1, 1);
        msg_block = b2;
        stream(1, -1, 0);
        @(negedge clock);
        #1;
        chk("b2b_accept_ready", {63'd0, msg_ready}, 64'd1);
        make_ref(b2);
        @(posedge clock);
        @(negedge clock);
        msg_valid = 1'b0;
        stream(0, -1, 0);

        // abort in IDLE alongside msg_valid: nothing accepted
        @(negedge clock);
        rand_block(b1);
        msg_block = b1;
        msg_valid = 1'b1;
        abort     = 1'b1;
        #1;
        chk("idle_abort_ready", {63'd0, msg_ready}, 64'd0);
        @(negedge clock);
        abort     = 1'b0;
        msg_valid = 1'b0;
        #1;
        chk("idle_abort_no_accept", {63'd0, w_valid}, 64'd0);
        chk("idle_abort_ready_back", {63'd0, msg_ready}, 64'd1);

        // Abort mid-stream, then a fresh block
        send(b1, 0);
        stream(1, 20, 1);
        rand_block(b2);
        send(b2, 0);
        stream(1, -1, 0);

        // Reset mid-stream, then a fresh block
        rand_block(b1);
        send(b1, 0);
        stream(0, 40, 2);
        rand_block(b2);
        send(b2, 0);
        stream(1, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/w_schedule_ctrl.md
Name: w_schedule_ctrl

Overview:
- Sequencer for the SHA-256 message schedule.
- Accepts one 512-bit message block over a valid/ready handshake and expands it in a 16-word sliding window (W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16]).
- Streams W[0]..W[W_LENGTH-1] to the compression round logic, one word per handshake, with full backpressure support.
- Sits between message padding/blocking and the compression core.

Parameters:
- W_LENGTH, 64: number of schedule words streamed per block; legal range 16..64.
- IDX_W, $clog2(W_LENGTH): width of w_index.

Ports:
- clock  input  1  clock
- reset  input  1  reset, synchronous, active-high
- abort  input  1  synchronous flush of the current block; returns to IDLE
- msg_valid  input  1  msg_block is valid
- msg_ready  output  1  block accepted when msg_valid && msg_ready
- msg_block  input  512  word i located at bits [32*i+31 : 32*i]
- w_valid  output  1  w_word/w_index valid
- w_ready  input  1  consumer accepts the word when w_valid && w_ready
- w_word  output  32  schedule word W[w_index]
- w_index  output  IDX_W  round index t of w_word
- w_last  output  1  high with w_valid when w_index == W_LENGTH-1
- block_done  output  1  one-cycle pulse, the cycle after the last word's handshake

Behaviour:
- States: IDLE, STREAM, DONE. Encoding is free.
- Reset (reset=1 at a clock edge), all outputs:
  - state=IDLE, msg_ready=0 during reset, w_valid=0, w_word=0, w_index=0, w_last=0, block_done=0.
  - Window registers win[0..15] cleared to 0.
- IDLE:
  - msg_ready=1, w_valid=0.
  - On msg_valid && msg_ready: win[i] <= msg_block word i, t <= 0, go to STREAM.
- STREAM:
  - msg_ready=0, w_valid=1, w_word=win[0], w_index=t, w_last=(t==W_LENGTH-1).
  - First word is valid the cycle after block acceptance (latency 1).
  - On w_valid && w_ready:
    - win[k] <= win[k+1] for k=0..14.
    - win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0], modulo 2^32.
    - t <= t+1.
    - If t==W_LENGTH-1: go to DONE.
  - Without w_ready: window, t and all outputs hold stable. No output may change while w_valid && !w_ready.
- σ functions:
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - XOR, not addition.
  - Computed combinationally from window registers; no extra pipeline stage.
- DONE (1 cycle):
  - block_done=1, w_valid=0, msg_ready=0; go to IDLE.
  - Next block can be accepted 2 cycles after the last word's handshake.
- Throughput: 1 word/cycle with w_ready held high. A block occupies W_LENGTH+2 cycles, including the accept and DONE cycles.
- abort:
  - In any state, abort=1 forces state=IDLE next cycle, w_valid=0, t=0. block_done is not pulsed.
  - abort has priority over a coincident handshake; the word is treated as not consumed.
  - abort in IDLE together with msg_valid: block not accepted, msg_ready=0 that cycle.
- reset has priority over abort and all handshakes.
- msg_block is sampled only on the accept cycle and may change afterwards.
- w_index wraps never: the FSM leaves STREAM at W_LENGTH-1.

Optional Feature:
- Macro W_VECTOR_OUT_EN.
- Defined:
  - Adds output w_vector [32*W_LENGTH-1:0]. Each streamed word is written into bits [32*t+31 : 32*t] on its handshake.
  - Cleared to 0 on reset and on block acceptance. Holds its value through DONE/IDLE until the next acceptance.
  - Lets debug and compatibility logic consume the full schedule at block_done.
- Not defined: port and storage absent; behaviour otherwise identical.

Test Plan:
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> expect the following, then block_done one cycle after w_last:
  - w_index 0..63 on consecutive cycles.
  - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6.
- Backpressure: same block, w_ready toggled pseudo-randomly -> identical word sequence to the reference model; w_word/w_index stable whenever w_ready=0.
- Back-to-back: two blocks with msg_valid held high -> second accepted exactly 2 cycles after first w_last handshake; second block's W0 correct.
- Abort at t=20 mid-stream -> next cycle w_valid=0, msg_ready=1, no block_done; following block streams correctly from W0.
- Reset asserted at t=40 -> all outputs 0 next cycle; after release msg_ready=1 and a new block streams from t=0.
- W_VECTOR_OUT_EN build, "abc" block -> at block_done, w_vector[31:0]=0x61626380 and w_vector[575:544]=0x000F0000.
